// File: rtl/proc_pkg.sv
// Shared definitions for the ALU/register-file processor and its host-side sequencer:
// sequencer states, instruction field layout, opcodes and ALU function codes.
package proc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    localparam int OPC_LSB  = 0;
    localparam int FUNC_LSB = 3;
    localparam int REG2_LSB = 7;
    localparam int REG1_LSB = 10;
    localparam int REGW_LSB = 13;

    localparam logic [2:0]  OPC_REGWRITE = 3'b011;
    localparam logic [15:0] INST_NOP     = 16'h0000;

    typedef enum logic [3:0] {
        FUNC_AND   = 4'd0,
        FUNC_OR    = 4'd1,
        FUNC_XOR   = 4'd2,
        FUNC_NOT   = 4'd3,
        FUNC_NAND  = 4'd4,
        FUNC_NOR   = 4'd5,
        FUNC_ADD   = 4'd6,
        FUNC_SUB   = 4'd7,
        FUNC_INC   = 4'd8,
        FUNC_DEC   = 4'd9,
        FUNC_MUL   = 4'd10,
        FUNC_CMP   = 4'd11,
        FUNC_PASSA = 4'd12,
        FUNC_PASSB = 4'd13,
        FUNC_SHL   = 4'd14,
        FUNC_SHR   = 4'd15
    } alu_func_e;

    function automatic logic [15:0] make_inst(input logic [2:0] regw, input logic [2:0] reg1,
                                              input logic [2:0] reg2, input logic [3:0] func,
                                              input logic [2:0] opc);
        logic [15:0] w;
        w = 16'h0000;
        w[REGW_LSB +: 3] = regw;
        w[REG1_LSB +: 3] = reg1;
        w[REG2_LSB +: 3] = reg2;
        w[FUNC_LSB +: 4] = func;
        w[OPC_LSB  +: 3] = opc;
        return w;
    endfunction

endpackage

// File: rtl/seq_buf.sv
// DEPTH x W buffer with synchronous write and registered read. BYPASS=1 forwards a
// same-cycle write to the read register; BYPASS=0 returns the old contents.
module seq_buf #(
    parameter int DEPTH  = 8,
    parameter int W      = 16,
    parameter int BYPASS = 0,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Storage array write port; contents are not reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if ((BYPASS != 0) && we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_sequencer.sv
// Host-side initiator: loads a program byte-serially, issues each instruction for
// RES_LAT+1 cycles and captures {zero, result} into a readable result buffer.
module inst_sequencer
    import proc_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int RES_LAT = 1,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_prog,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   prog_len,
    output logic [15:0]   inst_out,
    output logic          inst_valid,
    input  logic [7:0]    alu_result_in,
    input  logic          zero_in,
    input  logic [AW-1:0] rd_addr,
    output logic [8:0]    rd_data
);

    localparam int          HW        = (RES_LAT > 0) ? $clog2(RES_LAT + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RES_LAT);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_C     = (AW + 1)'(1);

    seq_state_e     state_q, state_d;
    logic [AW:0]    len_q, len_d;
    logic           phase_q, phase_d;
    logic [7:0]     low_q, low_d;
    logic [AW:0]    idx_q, idx_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           done_q, done_d;

    logic           ld_ready_s;
    logic           ib_we_s;
    logic [AW-1:0]  ib_raddr_s;
    logic [15:0]    ib_rdata_s;
    logic           rb_we_s;

    // Next-state: byte loading, start handling and instruction issue/capture
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        phase_d    = phase_q;
        low_d      = low_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        done_d     = 1'b0;
        ib_we_s    = 1'b0;
        ib_raddr_s = '0;
        rb_we_s    = 1'b0;
        ld_ready_s = (state_q != ST_RUN) && (len_q < DEPTH_C);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (clr_prog) begin
                    len_d   = '0;
                    phase_d = 1'b0;
                end else if (ld_valid && ld_ready_s) begin
                    if (phase_q) begin
                        ib_we_s = 1'b1;
                        len_d   = len_q + ONE_C;
                        phase_d = 1'b0;
                    end else begin
                        low_d   = ld_data;
                        phase_d = 1'b1;
                    end
                end else begin
                    len_d = len_q;
                end
                // start sees the length after this cycle's load commit
                if (start) begin
                    idx_d  = '0;
                    hold_d = '0;
                    if (len_d == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (hold_q == HOLD_LAST) begin
                    rb_we_s    = 1'b1;
                    hold_d     = '0;
                    idx_d      = idx_q + ONE_C;
                    ib_raddr_s = idx_d[AW-1:0];
                    if (idx_d == len_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    hold_d     = hold_q + HW'(1);
                    ib_raddr_s = idx_q[AW-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            phase_q <= 1'b0;
            low_q   <= 8'h00;
            idx_q   <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            phase_q <= phase_d;
            low_q   <= low_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    // Read address is prefetched, so bypass lets a load and start in one cycle work
    seq_buf #(.DEPTH(DEPTH), .W(16), .BYPASS(1)) u_ibuf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ib_we_s),
        .waddr_i (len_q[AW-1:0]),
        .wdata_i ({ld_data, low_q}),
        .raddr_i (ib_raddr_s),
        .rdata_o (ib_rdata_s)
    );

    seq_buf #(.DEPTH(DEPTH), .W(9), .BYPASS(0)) u_rbuf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (rb_we_s),
        .waddr_i (idx_q[AW-1:0]),
        .wdata_i ({zero_in, alu_result_in}),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign ld_ready   = ld_ready_s;
    assign busy       = (state_q == ST_RUN);
    assign inst_valid = (state_q == ST_RUN);
    assign inst_out   = (state_q == ST_RUN) ? ib_rdata_s : INST_NOP;
    assign done       = done_q;
    assign prog_len   = len_q;

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Host-side initiator for the 16-bit instruction port of the ALU/register-file processor.
- Loads a short program byte-serially into a local instruction buffer, then issues each instruction on the processor's instruction bus.
- Captures the processor's 8-bit ALU result and zero flag for every issued instruction into a result buffer that the host can read back.

Parameters:
- DEPTH, 8, number of instruction/result entries (power of two, >=2).
- RES_LAT, 1, cycles from instruction presentation to a valid ALU result (the register file reads through a register).
- AW, $clog2(DEPTH), buffer address width (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- clr_prog  in  1  pulse: empty instruction buffer (honoured in IDLE/DONE only)
- ld_valid  in  1  load byte strobe
- ld_data  in  8  load byte, low byte of instruction first
- ld_ready  out  1  buffer accepts a byte this cycle
- start  in  1  pulse: begin executing loaded program
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when last result captured
- prog_len  out  AW+1  number of complete instructions loaded
- inst_out  out  16  instruction to processor {regw[15:13], reg1[12:10], reg2[9:7], func[6:3], opcode[2:0]}
- inst_valid  out  1  inst_out carries a program instruction
- alu_result_in  in  8  processor ALU result
- zero_in  in  1  processor zero flag
- rd_addr  in  AW  result buffer read address
- rd_data  out  9  {zero, result[7:0]} at rd_addr, registered

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, prog_len=0, byte phase=low.
  - inst_out=16'h0000, inst_valid=0, busy=0, done=0, rd_data=0, ld_ready=1.
  - Result buffer contents are don't-care.
- States: IDLE, RUN, DONE.
- Load (IDLE or DONE, ld_ready=1):
  - The low byte is held in a staging register.
  - The next accepted byte forms {high, low}, written to entry prog_len; prog_len increments.
  - ld_ready = (state != RUN) && (prog_len < DEPTH). Bytes offered while ld_ready=0 are dropped.
  - A lone low byte is not counted. clr_prog clears prog_len and the byte phase.
  - clr_prog and ld_valid in the same cycle: clr wins, the byte is dropped.
- start in IDLE/DONE:
  - prog_len=0: go straight to DONE; done pulses next cycle; no instruction is issued.
  - Otherwise enter RUN with issue index=0.
  - start during RUN is ignored. start and a completing load byte in the same cycle: the load commits first and start uses the updated prog_len.
- RUN:
  - Each instruction is held on inst_out with inst_valid=1 for exactly RES_LAT+1 cycles.
  - In the last hold cycle, {zero_in, alu_result_in} is written to result entry index.
  - Index increments and the next instruction appears the following cycle, with no gaps.
  - Total RUN length = prog_len*(RES_LAT+1) cycles.
  - After the last capture: inst_out=0, inst_valid=0, state=DONE, done=1 for one cycle.
- Idle bus: outside RUN, inst_out=16'h0000 (opcode 000: no register write).
- DONE: behaves as IDLE for load/start/clr. The program is retained, so start re-runs it.
- Readback: rd_data <= result[rd_addr] every cycle (1-cycle latency), in any state. During RUN, reading an entry being written returns the old value.
- Reset mid-RUN: returns to IDLE and prog_len=0; the host must reload.
- Widths: the index counter is AW+1 bits to avoid wrap at DEPTH entries; the hold counter is $clog2(RES_LAT+1) bits, minimum 1.

Decomposition:
- Shared package proc_pkg:
  - State enum.
  - Instruction field offsets (OPC_LSB=0, FUNC_LSB=3, REG2_LSB=7, REG1_LSB=10, REGW_LSB=13).
  - OPC_REGWRITE=3'b011.
  - ALU func codes (AND=0 … SHR=15).
  - INST_NOP=16'h0000.
- One natural sub-module, seq_buf: a DEPTH×W synchronous-write, registered-read buffer. Instantiate twice: W=16 for instructions, W=9 for results.

Test Plan:
- Reset then load bytes 0x1B,0x24 (inst 0x241B) → prog_len=1, ld_ready=1; start → inst_out=0x241B, inst_valid high for 2 cycles; done pulses once; busy low after.
- Load 8 instructions, then offer a 9th pair → ld_ready=0 after the 8th; 9th dropped; prog_len=8. RUN lasts 16 cycles; inst_out steps through all 8 in order.
- Processor model returns alu_result_in=0x0C with zero_in=0 for inst 0x2433 (func ADD, opcode 011) and 0x00 with zero_in=1 for an XOR r,r → rd_addr=0 gives 0x00C; rd_addr=1 gives 0x100, one cycle after each address is applied.
- start with prog_len=0 → done pulses next cycle; inst_valid never asserted.
- Assert rst in the 3rd cycle of RUN → next cycle inst_out=0, inst_valid=0, busy=0, prog_len=0, no done pulse.
- Complete a run, then start again without reload → identical inst_out sequence and identical rd_data; start pulsed during RUN has no effect on the cycle count.
